alu_control_seq: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_op_decode.sv | 65 ++++++
 rtl/alu_control_seq.sv | 115 +++++++++++
 tb/tb_alu_control_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared op codes, ALUOp encodings and state types for the ALU control sequencer
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SLT = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [1:0] {CLS_SINGLE, CLS_SHIFT, CLS_MUL} op_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/Funct/opcode lookup into op code, cycle class and illegal flag
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 2
) (
  input  logic [1:0]         i_aluop,
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [3:0]         i_opcode,
  output logic [OP_W-1:0]    o_code,
  output op_class_t          o_cls,
  output logic               o_illegal
);

  logic w_f0, w_f1, w_f2, w_f3;

  assign w_f0 = (i_funct == FUNCT_W'(0));
  assign w_f1 = (i_funct == FUNCT_W'(1));
  assign w_f2 = (i_funct == FUNCT_W'(2));
  assign w_f3 = (i_funct == FUNCT_W'(3));

  always_comb begin
    o_code    = OP_W'(OP_NOP);
    o_cls     = CLS_SINGLE;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_MEM: o_code = OP_W'(OP_ADD);
      ALUOP_BR:  o_code = OP_W'(OP_SUB);
      ALUOP_R: begin
        if (w_f0 && i_opcode == 4'b0000)      o_code = OP_W'(OP_AND);
        else if (w_f0 && i_opcode == 4'b0001) o_code = OP_W'(OP_ADD);
        else if (w_f1 && i_opcode == 4'b0000) o_code = OP_W'(OP_OR);
        else if (w_f1 && i_opcode == 4'b0001) o_code = OP_W'(OP_SUB);
        else if (w_f2)                        o_code = OP_W'(OP_XOR);
        else if (w_f3 && i_opcode == 4'b0001) begin
          o_code = OP_W'(OP_MUL);
          o_cls  = CLS_MUL;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: begin
        // ALUOP_I: immediates ignore Funct; opcode 0010 selects a shift by Funct
        case (i_opcode)
          4'b1001: o_code = OP_W'(OP_ADD);
          4'b1010: o_code = OP_W'(OP_SUB);
          4'b1011: o_code = OP_W'(OP_SLT);
          4'b0010: begin
            o_cls = CLS_SHIFT;
            if (w_f0)      o_code = OP_W'(OP_SLL);
            else if (w_f1) o_code = OP_W'(OP_SRA);
            else if (w_f2) o_code = OP_W'(OP_SRL);
            else begin
              o_cls     = CLS_SINGLE;
              o_illegal = 1'b1;
            end
          end
          default: o_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - sequenced ALU control: issue handshake, multi-cycle shift/multiply stepping
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int  DATA_W  = 16,
  parameter int  OP_W    = 4,
  parameter int  FUNCT_W = 2,
  localparam int SH_W    = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [3:0]         opcode,
  input  logic [SH_W-1:0]    shamt,
  output logic [OP_W-1:0]    Operacioni,
  output logic               step,
  output logic               last,
  output logic               illegal,
  output logic               busy
);

  localparam int CNT_W = SH_W + 1;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [OP_W-1:0]   r_op, w_op_nxt;
  logic              r_step, w_step_nxt;
  logic              r_illegal, w_illegal_nxt;

  logic [OP_W-1:0]   w_code;
  op_class_t         w_cls;
  logic              w_dec_illegal;
  logic              w_accept;
  logic              w_last;
  logic              w_pass;
  logic [CNT_W-1:0]  w_n;

  alu_op_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .i_aluop   (ALUOp),
    .i_funct   (Funct),
    .i_opcode  (opcode),
    .o_code    (w_code),
    .o_cls     (w_cls),
    .o_illegal (w_dec_illegal)
  );

  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(1));
  assign in_ready = (r_state == IDLE) || w_last;
  assign w_accept = in_valid && in_ready;
  assign w_pass   = (w_cls == CLS_SHIFT) && (shamt == '0);

  // Zero-length shifts and illegal requests still occupy one (non-stepping) cycle
  always_comb begin
    w_n = CNT_W'(1);
    case (w_cls)
      CLS_MUL:   w_n = CNT_W'(DATA_W);
      CLS_SHIFT: w_n = w_pass ? CNT_W'(1) : {1'b0, shamt};
      default:   w_n = CNT_W'(1);
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_op_nxt      = r_op;
    w_step_nxt    = r_step;
    w_illegal_nxt = r_illegal;
    if (w_accept) begin
      w_state_nxt   = RUN;
      w_cnt_nxt     = w_n;
      w_op_nxt      = w_code;
      w_step_nxt    = !(w_dec_illegal || w_pass);
      w_illegal_nxt = w_dec_illegal;
    end else if (r_state == RUN) begin
      if (w_last) begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
        w_op_nxt      = OP_W'(OP_NOP);
        w_step_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= OP_W'(OP_NOP);
      r_step    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_step    <= w_step_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign Operacioni = r_op;
  assign step       = r_step;
  assign last       = w_last;
  assign illegal    = r_illegal;
  assign busy       = (r_state == RUN);

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - self-checking bench for alu_control_seq against a per-cycle expectation queue
module tb_alu_control_seq;

  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic [1:0] Funct;
  logic [3:0] opcode;
  logic [3:0] shamt;
  logic [3:0] Operacioni;
  logic       step, last, illegal, busy;

  logic       v32, rdy32, step32, last32, ill32, busy32;
  logic [1:0] a32, f32;
  logic [3:0] o32, op32;
  logic [4:0] sh32;

  int n_checks = 0;
  int n_fail   = 0;

  // Rule: {aluop[15:14], funct[13:12], funct_care[11], opcode[10:7], opcode_care[6], code[5:2], kind[1:0]}
  // kind 0 = one cycle, 1 = shift by shamt, 2 = multiply (DW cycles)
  logic [15:0] rules[$];
  // Expected per-cycle record: {op[6:3], step[2], last[1], illegal[0]}
  logic [6:0]  q[$];

  always #5 clk = ~clk;

  alu_control_seq #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .opcode(opcode), .shamt(shamt),
    .Operacioni(Operacioni), .step(step), .last(last), .illegal(illegal), .busy(busy)
  );

  alu_control_seq #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
    .ALUOp(a32), .Funct(f32), .opcode(o32), .shamt(sh32),
    .Operacioni(op32), .step(step32), .last(last32), .illegal(ill32), .busy(busy32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_rule(input logic [1:0] a, input logic [1:0] f, input logic fc,
                          input logic [3:0] o, input logic oc, input logic [3:0] code, input logic [1:0] kind);
    rules.push_back({a, f, fc, o, oc, code, kind});
  endtask

  task automatic model_accept(input logic [1:0] a, input logic [1:0] f, input logic [3:0] o, input logic [3:0] sh);
    logic [15:0] r;
    logic        found;
    logic [3:0]  code;
    logic [1:0]  kind;
    int          n;
    logic        pass;
    found = 1'b0;
    code  = 4'b1111;
    kind  = 2'd0;
    foreach (rules[i]) begin
      r = rules[i];
      if (!found && r[15:14] == a && (!r[11] || r[13:12] == f) && (!r[6] || r[10:7] == o)) begin
        found = 1'b1;
        code  = r[5:2];
        kind  = r[1:0];
      end
    end
    if (!found) begin
      q.push_back({4'b1111, 1'b0, 1'b1, 1'b1});
    end else begin
      pass = (kind == 2'd1) && (sh == 4'd0);
      n = (kind == 2'd2) ? DW : (kind == 2'd1 && !pass) ? int'(sh) : 1;
      for (int i = 0; i < n; i++) q.push_back({code, !pass, (i == n - 1), 1'b0});
    end
  endtask

  // Check this cycle's outputs, then drive the next request and advance one clock
  task automatic cyc(input string tag, input logic rst, input logic v, input logic [1:0] a,
                     input logic [1:0] f, input logic [3:0] o, input logic [3:0] sh);
    logic [6:0] e;
    logic       busy_e, ready_e;
    if (q.size() > 0) begin
      e = q.pop_front();
      busy_e = 1'b1;
    end else begin
      e = {4'b1111, 1'b0, 1'b0, 1'b0};
      busy_e = 1'b0;
    end
    ready_e = (q.size() == 0);
    chk({tag, ".op"},    32'(Operacioni), 32'(e[6:3]));
    chk({tag, ".step"},  32'(step),       32'(e[2]));
    chk({tag, ".last"},  32'(last),       32'(e[1]));
    chk({tag, ".ill"},   32'(illegal),    32'(e[0]));
    chk({tag, ".busy"},  32'(busy),       32'(busy_e));
    chk({tag, ".ready"}, 32'(in_ready),   32'(ready_e));
    reset = rst; in_valid = v; ALUOp = a; Funct = f; opcode = o; shamt = sh;
    if (rst) q.delete();
    else if (v && ready_e) model_accept(a, f, o, sh);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0, 4'h0);
  endtask

  initial begin
    int cnt32;
    add_rule(2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 4'b0100, 2'd0);
    add_rule(2'b01, 2'b00, 1'b0, 4'h0, 1'b0, 4'b1100, 2'd0);
    add_rule(2'b10, 2'b00, 1'b1, 4'h0, 1'b1, 4'b0000, 2'd0);
    add_rule(2'b10, 2'b00, 1'b1, 4'h1, 1'b1, 4'b0100, 2'd0);
    add_rule(2'b10, 2'b01, 1'b1, 4'h0, 1'b1, 4'b0010, 2'd0);
    add_rule(2'b10, 2'b01, 1'b1, 4'h1, 1'b1, 4'b1100, 2'd0);
    add_rule(2'b10, 2'b10, 1'b1, 4'h0, 1'b0, 4'b0011, 2'd0);
    add_rule(2'b10, 2'b11, 1'b1, 4'h1, 1'b1, 4'b1000, 2'd2);
    add_rule(2'b11, 2'b00, 1'b0, 4'h9, 1'b1, 4'b0100, 2'd0);
    add_rule(2'b11, 2'b00, 1'b0, 4'hA, 1'b1, 4'b1100, 2'd0);
    add_rule(2'b11, 2'b00, 1'b0, 4'hB, 1'b1, 4'b0001, 2'd0);
    add_rule(2'b11, 2'b00, 1'b1, 4'h2, 1'b1, 4'b0110, 2'd1);
    add_rule(2'b11, 2'b01, 1'b1, 4'h2, 1'b1, 4'b0111, 2'd1);
    add_rule(2'b11, 2'b10, 1'b1, 4'h2, 1'b1, 4'b0101, 2'd1);

    reset = 1'b1; in_valid = 1'b0; ALUOp = '0; Funct = '0; opcode = '0; shamt = '0;
    v32 = 1'b0; a32 = '0; f32 = '0; o32 = '0; sh32 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single-cycle SUB, then back to NOP
    cyc("sub", 1'b0, 1'b1, 2'b10, 2'b01, 4'h1, 4'h0);
    idle("sub_after", 3);

    // Six back-to-back single-cycle ops
    cyc("b2b_lw",   1'b0, 1'b1, 2'b00, 2'b00, 4'h0, 4'h0);
    cyc("b2b_beq",  1'b0, 1'b1, 2'b01, 2'b00, 4'h0, 4'h0);
    cyc("b2b_and",  1'b0, 1'b1, 2'b10, 2'b00, 4'h0, 4'h0);
    cyc("b2b_or",   1'b0, 1'b1, 2'b10, 2'b01, 4'h0, 4'h0);
    cyc("b2b_xor",  1'b0, 1'b1, 2'b10, 2'b10, 4'h5, 4'h0);
    cyc("b2b_addi", 1'b0, 1'b1, 2'b11, 2'b00, 4'h9, 4'h0);
    idle("b2b_after", 2);

    // Shift by 5, then zero-length pass-through shift
    cyc("sll5", 1'b0, 1'b1, 2'b11, 2'b00, 4'h2, 4'd5);
    idle("sll5_run", 6);
    cyc("sll0", 1'b0, 1'b1, 2'b11, 2'b00, 4'h2, 4'd0);
    idle("sll0_after", 2);

    // Multiply, with SUBI accepted during its last cycle
    cyc("mul", 1'b0, 1'b1, 2'b10, 2'b11, 4'h1, 4'h0);
    idle("mul_run", 15);
    cyc("mul_last_subi", 1'b0, 1'b1, 2'b11, 2'b00, 4'hA, 4'h0);
    idle("subi_after", 2);

    // Illegal combination
    cyc("illegal", 1'b0, 1'b1, 2'b10, 2'b00, 4'h7, 4'h0);
    idle("illegal_after", 2);

    // SRA by 9 aborted by reset on its 4th cycle
    cyc("sra9", 1'b0, 1'b1, 2'b11, 2'b01, 4'h2, 4'd9);
    idle("sra9_run", 3);
    cyc("sra9_reset", 1'b1, 1'b0, 2'b00, 2'b00, 4'h0, 4'h0);
    idle("after_abort", 3);

    // Randomised traffic, biased toward decodable opcodes and short shifts
    for (int i = 0; i < 400; i++) begin
      logic [3:0] o;
      logic [3:0] sh;
      o  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) :
           (($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom_range(9, 11)));
      if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(0, 1));
      sh = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      cyc("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), o, sh);
    end
    idle("drain", 20);

    // 32-bit variant: multiply runs 32 stepping cycles
    v32 = 1'b1; a32 = 2'b10; f32 = 2'b11; o32 = 4'h1;
    @(posedge clk); #1;
    v32 = 1'b0;
    cnt32 = 0;
    for (int k = 0; k < 64; k++) begin
      chk("mul32.step", 32'(step32), 32'(1));
      chk("mul32.op",   32'(op32),   32'(4'b1000));
      cnt32++;
      if (last32) break;
      @(posedge clk); #1;
    end
    chk("mul32.cycles", 32'(cnt32), 32'(32));
    @(posedge clk); #1;
    chk("mul32.idle_ready", 32'(rdy32), 32'(1));
    chk("mul32.idle_op",    32'(op32),  32'(4'b1111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
